// File: rtl/binary2grey_pkg.sv
// Shared constants and reference conversion helpers for the binary/Gray converter.
// The helpers work on 64-bit words; callers mask to their own width.
package binary2grey_pkg;

    localparam int GREY_DEFAULT_W = 4;

    function automatic logic [63:0] bin2grey(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits decode to zero, so narrower words need no special handling.
    function automatic logic [63:0] grey2bin(input logic [63:0] g);
        logic [63:0] b;
        b[63] = g[63];
        for (int i = 62; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/binary_to_grey_if.sv
// Bundle for the binary-to-Gray converter; chk_err exists only when
// BINARY2GREY_CHECK_EN is defined.
interface binary2grey_int #(
    parameter int N = 4
) (
    input logic clk,
    input logic rst
);
    logic         in_valid;
    logic [N-1:0] binary;
    logic         out_valid;
    logic [N-1:0] grey;
`ifdef BINARY2GREY_CHECK_EN
    logic         chk_err;

    modport master (input clk, rst, out_valid, grey, chk_err, output in_valid, binary);
    modport slave  (input in_valid, binary, output out_valid, grey, chk_err);
`else
    modport master (input clk, rst, out_valid, grey, output in_valid, binary);
    modport slave  (input in_valid, binary, output out_valid, grey);
`endif
endinterface

// File: rtl/binary_to_grey_grey2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits from the MSB down to that position.
module grey2bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] grey,
    output logic [N-1:0] binary
);
    // Explicit suffix reduction per bit keeps the netlist free of a self-referencing vector.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign binary[gi] = ^grey[N-1:gi];
        end
    endgenerate
endmodule

// File: rtl/binary_to_grey.sv
// Registered binary-to-Gray converter, one cycle latency, no back-pressure.
// Optional round-trip self-check enabled by BINARY2GREY_CHECK_EN.
module binary_to_grey
    import binary2grey_pkg::*;
#(
    parameter int N = GREY_DEFAULT_W
) (
    input logic                clk,
    input logic                rst,
    binary2grey_int.slave      bus
);
    logic [N-1:0] grey_next;
    logic [N-1:0] grey_reg;
    logic         out_valid_reg;

    generate
        assign grey_next[N-1] = bus.binary[N-1];
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_conv
            assign grey_next[gi] = bus.binary[gi + 1] ^ bus.binary[gi];
        end
    endgenerate

    // grey holds its last value when idle; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            grey_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                grey_reg <= grey_next;
            end
        end
    end

    assign bus.grey      = grey_reg;
    assign bus.out_valid = out_valid_reg;

`ifdef BINARY2GREY_CHECK_EN
    logic [N-1:0] shadow_reg;
    logic [N-1:0] decoded;
    logic         chk_err_reg;

    grey2bin #(.N(N)) u_dec (
        .grey   (grey_reg),
        .binary (decoded)
    );

    // Shadow tracks the word that produced grey_reg, so the check sits beside
    // the output path and never delays it.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg  <= '0;
            chk_err_reg <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                shadow_reg <= bus.binary;
            end
            if (out_valid_reg && (decoded != shadow_reg)) begin
                chk_err_reg <= 1'b1;
            end
        end
    end

    assign bus.chk_err = chk_err_reg;
`endif
endmodule

// File: tb/tb_binary_to_grey.sv
// Directed bench for binary_to_grey at widths 4, 1, 8 and 64; the self-check
// section runs only when BINARY2GREY_CHECK_EN is defined.
module tb_binary_to_grey;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    binary2grey_int #(.N(4))  bus4  (.clk(clk), .rst(rst));
    binary2grey_int #(.N(1))  bus1  (.clk(clk), .rst(rst));
    binary2grey_int #(.N(8))  bus8  (.clk(clk), .rst(rst));
    binary2grey_int #(.N(64)) bus64 (.clk(clk), .rst(rst));

    binary_to_grey #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
    binary_to_grey #(.N(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
    binary_to_grey #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    binary_to_grey #(.N(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, act);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp4 [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    logic [3:0] prev_grey;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        bus4.in_valid  = 1'b1; bus4.binary  = 4'hF;
        bus1.in_valid  = 1'b0; bus1.binary  = 1'b0;
        bus8.in_valid  = 1'b0; bus8.binary  = 8'h00;
        bus64.in_valid = 1'b0; bus64.binary = 64'h0;

        // Reset held two cycles with a valid all-ones word present.
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq($sformatf("reset%0d_grey", i), 64'(bus4.grey), 64'h0);
            check_eq($sformatf("reset%0d_valid", i), 64'(bus4.out_valid), 64'h0);
        end
        check_eq("reset_grey64", bus64.grey, 64'h0);

        // Exhaustive N=4 back-to-back, then wrap to 0.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus4.in_valid = 1'b1;
            bus4.binary   = 4'(i);
            step();
            check_eq($sformatf("n4_bin%0d", i), 64'(bus4.grey), 64'(exp4[i]));
            check_eq($sformatf("n4_valid%0d", i), 64'(bus4.out_valid), 64'h1);
            if (i > 0) begin
                check_eq($sformatf("n4_onebit%0d", i), 64'($countones(bus4.grey ^ prev_grey)), 64'h1);
            end
            prev_grey = bus4.grey;
        end
        bus4.binary = 4'd0;
        step();
        check_eq("n4_wrap_grey", 64'(bus4.grey), 64'h0);
        check_eq("n4_wrap_onebit", 64'($countones(bus4.grey ^ prev_grey)), 64'h1);

        // Hold: last value retained while idle.
        bus4.binary = 4'd6;
        step();
        check_eq("hold_load", 64'(bus4.grey), 64'h5);
        bus4.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus4.binary = 4'(i + 9);
            step();
            check_eq($sformatf("hold%0d_grey", i), 64'(bus4.grey), 64'h5);
            check_eq($sformatf("hold%0d_valid", i), 64'(bus4.out_valid), 64'h0);
        end

        // Reset mid-stream discards the word presented with it.
        bus4.in_valid = 1'b1;
        bus4.binary   = 4'd9;
        step();
        check_eq("mid_pre", 64'(bus4.grey), 64'hD);
        rst = 1'b1;
        bus4.binary = 4'd7;
        step();
        check_eq("mid_rst_grey", 64'(bus4.grey), 64'h0);
        check_eq("mid_rst_valid", 64'(bus4.out_valid), 64'h0);
        rst = 1'b0;
        bus4.binary = 4'd3;
        step();
        check_eq("post_rst_grey", 64'(bus4.grey), 64'h2);
        check_eq("post_rst_valid", 64'(bus4.out_valid), 64'h1);
        bus4.in_valid = 1'b0;

        // Width corners.
        bus1.in_valid = 1'b1; bus8.in_valid = 1'b1; bus64.in_valid = 1'b1;
        bus1.binary = 1'b0; bus8.binary = 8'hFF; bus64.binary = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check_eq("n1_0", 64'(bus1.grey), 64'h0);
        check_eq("n8_ff", 64'(bus8.grey), 64'h80);
        check_eq("n64_ones", bus64.grey, 64'h8000_0000_0000_0000);
        check_eq("n64_valid", 64'(bus64.out_valid), 64'h1);
        bus1.binary = 1'b1; bus8.binary = 8'h80;
        step();
        check_eq("n1_1", 64'(bus1.grey), 64'h1);
        check_eq("n8_80", 64'(bus8.grey), 64'hC0);
        bus1.in_valid = 1'b0; bus8.in_valid = 1'b0; bus64.in_valid = 1'b0;

`ifdef BINARY2GREY_CHECK_EN
        // Round-trip check stays quiet on a clean random stream.
        bus4.in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus4.binary = 4'($urandom_range(0, 15));
            step();
        end
        step();
        check_eq("chk_clean", 64'(bus4.chk_err), 64'h0);

        // Corrupt the output register; the sticky flag must rise and stay.
        bus4.binary = 4'd0;
        step();
        force u_dut4.grey_reg = 4'hF;
        step();
        step();
        release u_dut4.grey_reg;
        check_eq("chk_set", 64'(bus4.chk_err), 64'h1);
        for (int i = 0; i < 3; i++) begin
            bus4.binary = 4'(i);
            step();
        end
        check_eq("chk_sticky", 64'(bus4.chk_err), 64'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("chk_cleared", 64'(bus4.chk_err), 64'h0);
        bus4.in_valid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/binary_to_grey.md
# binary_to_grey

Registered binary-to-Gray-code converter. Each cycle it accepts an N-bit binary word qualified by a valid strobe and produces the reflected Gray code one clock later. It sits between counters or address generators and clock-domain-crossing or position-encoding logic that needs single-bit-change sequences.

## Interface
Parameters:
- `N`, default 4: data width in bits; legal range 1..64.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  qualifies `binary` this cycle.
- `binary`  in  N  binary input word.
- `out_valid`  out  1  `grey` holds a freshly converted word.
- `grey`  out  N  registered Gray-code output.
- `chk_err`  out  1  round-trip mismatch flag; present only with `BINARY2GREY_CHECK_EN`.

## Operation
- Conversion: `grey[N-1] = binary[N-1]`; `grey[i] = binary[i+1] ^ binary[i]` for i < N-1. This is equivalent to `binary ^ (binary >> 1)` with a logical shift.
- When `in_valid=1` at a rising edge, `grey` loads the converted `binary` and `out_valid` is set to 1.
- When `in_valid=0`, `grey` holds its last value and `out_valid` is set to 0.
- There is no back-pressure. Every valid input produces exactly one valid output on the next cycle.
- Width rules: the output width always equals the input width; no sign handling. When N=1, `grey` equals `binary`.
- Wrap-around: the input step 2^N-1 -> 0 produces a single-bit output change (MSB only).

## Timing
- Latency: 1 cycle from `in_valid`/`binary` to `grey`/`out_valid`.
- Throughput: 1 word per cycle; back-to-back valid inputs are allowed.
- Reset state: `grey = 0`, `out_valid = 0`, `chk_err = 0`.
- `rst` takes priority over `in_valid` in the same cycle; the input presented in that cycle is discarded.
- Reset mid-stream: outputs clear on the next edge. The first valid input after `rst` deasserts produces output one cycle later, as normal.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `BINARY2GREY_CHECK_EN`.
- Defined:
  - A Gray-to-binary decoder re-derives binary from the registered `grey`.
  - The result is compared against a registered copy of the accepted `binary`.
  - `chk_err` is set, a sticky flag, on any mismatch while `out_valid=1`, and cleared only by `rst`.
  - The check adds no latency to `grey`.
- Undefined: the decoder, the shadow register and the `chk_err` port are absent.

## Structure
- Shared package `binary2grey_pkg` contains:
  - `localparam int GREY_DEFAULT_W = 4`.
  - Functions `bin2grey(logic [63:0])` and `grey2bin(logic [63:0])`, width-masked by the caller, for reuse by the bench reference model.
- Sub-module `grey2bin`:
  - Combinational prefix-XOR decoder: `b[N-1] = g[N-1]`; `b[i] = b[i+1] ^ g[i]`.
  - Instantiated only under `BINARY2GREY_CHECK_EN`.
- Bench interface `binary2grey_int` bundles `clk`, `rst`, `in_valid`, `binary`, `out_valid`, `grey`, `chk_err`.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `in_valid=1`, `binary=4'hF` -> `grey=0`, `out_valid=0` throughout.
- Exhaustive N=4: drive 0..15 back-to-back. Required outputs one cycle later, in order: 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.
  - Spot checks: 5->7, 8->12, 15->8.
  - Every adjacent output pair, including 15->0, differs in exactly one bit.
- Hold: valid `binary=4'd6` -> `grey=4'd5`. Then `in_valid=0` for 3 cycles with `binary` changing -> `grey` stays 5, `out_valid=0`.
- Reset mid-stream: assert `rst` during a valid stream -> next edge `grey=0`, `out_valid=0`. First post-reset input `binary=3` -> `grey=2` one cycle later.
- Width corners:
  - N=1: 0->0, 1->1.
  - N=8: 8'hFF->8'h80, 8'h80->8'hC0.
  - N=64: all-ones -> MSB only set.
- With `BINARY2GREY_CHECK_EN`: a random 1000-word stream -> `chk_err=0`. Forcing a bit of the internal `grey` register -> `chk_err=1` and it remains set until `rst`.
